// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared types and constants for the control_unit sequencer:
//   FSM state encoding, instruction opcodes, ALU operation codes and
//   the DECODE-state next-state lookup.
package control_unit_pkg;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD_A = 4'd3,
        LOAD_B = 4'd4,
        STORE  = 4'd5,
        ADD    = 4'd6,
        SUB    = 4'd7,
        NOOP   = 4'd8,
        HALT   = 4'd9
    } state_t;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOOP  = 4'd0;
    localparam opcode_t OP_STORE = 4'd1;
    localparam opcode_t OP_LOAD  = 4'd2;
    localparam opcode_t OP_ADD   = 4'd3;
    localparam opcode_t OP_SUB   = 4'd4;
    localparam opcode_t OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_ZERO = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // Opcodes 6..15 fall through to NOOP.
    function automatic state_t next_from_opcode(input opcode_t op);
        case (op)
            OP_STORE: return STORE;
            OP_LOAD:  return LOAD_A;
            OP_ADD:   return ADD;
            OP_SUB:   return SUB;
            OP_HALT:  return HALT;
            default:  return NOOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// control_unit_decode
//   Combinational Moore decode: current state + latched instruction operand
//   field -> datapath control word.
// Ports
//   i_state       current FSM state
//   i_ir          IR[11:0] (operand field of the latched instruction)
//   o_d_addr      data-memory address
//   o_d_wr        data-memory write enable
//   o_rf_s        WriteData mux select (0 = ALU, 1 = DMEM)
//   o_rf_w_addr   RF write address
//   o_rf_w_en     RF write enable
//   o_rf_ra_addr  RF read port A address
//   o_rf_rb_addr  RF read port B address
//   o_alu_s0      ALU operation select
//   o_halted      high in HALT
module control_unit_decode
    import control_unit_pkg::*;
#(
    parameter int DADDR_W = 8,
    parameter int RF_AW   = 4
) (
    input  state_t             i_state,
    input  logic [11:0]        i_ir,
    output logic [DADDR_W-1:0] o_d_addr,
    output logic               o_d_wr,
    output logic               o_rf_s,
    output logic [RF_AW-1:0]   o_rf_w_addr,
    output logic               o_rf_w_en,
    output logic [RF_AW-1:0]   o_rf_ra_addr,
    output logic [RF_AW-1:0]   o_rf_rb_addr,
    output logic [2:0]         o_alu_s0,
    output logic               o_halted
);

    logic [DADDR_W-1:0] w_mem_addr;
    logic [RF_AW-1:0]   w_reg_lo;
    logic [RF_AW-1:0]   w_reg_mid;
    logic [RF_AW-1:0]   w_reg_hi;

    assign w_mem_addr = DADDR_W'(i_ir[11:4]);
    assign w_reg_lo   = RF_AW'(i_ir[3:0]);
    assign w_reg_mid  = RF_AW'(i_ir[7:4]);
    assign w_reg_hi   = RF_AW'(i_ir[11:8]);

    always_comb begin
        o_d_addr     = '0;
        o_d_wr       = 1'b0;
        o_rf_s       = 1'b0;
        o_rf_w_addr  = '0;
        o_rf_w_en    = 1'b0;
        o_rf_ra_addr = '0;
        o_rf_rb_addr = '0;
        o_alu_s0     = ALU_ZERO;
        o_halted     = 1'b0;
        case (i_state)
            LOAD_A: begin
                o_d_addr = w_mem_addr;
            end
            LOAD_B: begin
                o_d_addr    = w_mem_addr;
                o_rf_s      = 1'b1;
                o_rf_w_addr = w_reg_lo;
                o_rf_w_en   = 1'b1;
            end
            STORE: begin
                o_d_addr     = w_mem_addr;
                o_rf_ra_addr = w_reg_lo;
                o_d_wr       = 1'b1;
            end
            ADD: begin
                o_rf_ra_addr = w_reg_hi;
                o_rf_rb_addr = w_reg_mid;
                o_rf_w_addr  = w_reg_lo;
                o_rf_w_en    = 1'b1;
                o_alu_s0     = ALU_ADD;
            end
            SUB: begin
                o_rf_ra_addr = w_reg_hi;
                o_rf_rb_addr = w_reg_mid;
                o_rf_w_addr  = w_reg_lo;
                o_rf_w_en    = 1'b1;
                o_alu_s0     = ALU_SUB;
            end
            HALT: begin
                o_halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Moore FSM sequencer for a small processor datapath. Owns PC and IR,
//   fetches one 16-bit instruction from a synchronous-read IMEM, decodes it
//   and drives RF / ALU / mux / DMEM controls for LOAD, STORE, ADD, SUB,
//   NOOP and HALT.
// Configuration
//   CONTROL_UNIT_SINGLE_STEP_EN : adds input `step`; FETCH holds (PC frozen)
//                                 until step = 1 is sampled.
// Ports
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   step        (macro only) single-step advance
//   IR_in       instruction from IMEM, valid one cycle after PC_addr
//   PC_addr     IMEM address (PC register)
//   D_Addr, D_wr                    data-memory address / write enable
//   RF_s, RF_W_addr, RF_W_en        RF write-back mux, address, enable
//   RF_Ra_addr, RF_Rb_addr          RF read addresses
//   Alu_s0      ALU op select
//   halted      1 while in HALT
//   state_o     current state encoding (debug)
module control_unit
    import control_unit_pkg::*;
#(
    parameter int PC_W    = 7,
    parameter int DADDR_W = 8,
    parameter int RF_AW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [15:0]        IR_in,
    output logic [PC_W-1:0]    PC_addr,
    output logic [DADDR_W-1:0] D_Addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [RF_AW-1:0]   RF_W_addr,
    output logic               RF_W_en,
    output logic [RF_AW-1:0]   RF_Ra_addr,
    output logic [RF_AW-1:0]   RF_Rb_addr,
    output logic [2:0]         Alu_s0,
    output logic               halted,
    output logic [3:0]         state_o
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    // The opcode is consumed by the DECODE transition itself, so only the
    // operand field needs to be held for the execute states.
    logic [11:0]       r_ir;
    logic              w_fetch_go;

`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    assign w_fetch_go = step;
`else
    assign w_fetch_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                INIT:   r_state <= FETCH;
                FETCH:  if (w_fetch_go) r_state <= DECODE;
                DECODE: begin
                    r_ir    <= IR_in[11:0];
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= next_from_opcode(IR_in[15:12]);
                end
                LOAD_A: r_state <= LOAD_B;
                LOAD_B, STORE, ADD, SUB, NOOP: r_state <= FETCH;
                HALT:   r_state <= HALT;
                default: r_state <= INIT;
            endcase
        end
    end

    assign PC_addr = r_pc;
    assign state_o = r_state;

    control_unit_decode #(
        .DADDR_W (DADDR_W),
        .RF_AW   (RF_AW)
    ) u_decode (
        .i_state      (r_state),
        .i_ir         (r_ir),
        .o_d_addr     (D_Addr),
        .o_d_wr       (D_wr),
        .o_rf_s       (RF_s),
        .o_rf_w_addr  (RF_W_addr),
        .o_rf_w_en    (RF_W_en),
        .o_rf_ra_addr (RF_Ra_addr),
        .o_rf_rb_addr (RF_Rb_addr),
        .o_alu_s0     (Alu_s0),
        .o_halted     (halted)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Directed-vector bench for control_unit with a synchronous-read IMEM model.
//   Build with +define+CONTROL_UNIT_SINGLE_STEP_EN to include step tests.
module tb_control_unit;
    import control_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] IR_in;
    logic [6:0]  PC_addr;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;
    logic        halted;
    logic [3:0]  state_o;
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    logic        step;
`endif

    logic [15:0] imem [0:127];
    int unsigned n_tests;
    int unsigned n_fail;

    control_unit #(
        .PC_W    (7),
        .DADDR_W (8),
        .RF_AW   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        .step       (step),
`endif
        .IR_in      (IR_in),
        .PC_addr    (PC_addr),
        .D_Addr     (D_Addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .Alu_s0     (Alu_s0),
        .halted     (halted),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge clk) IR_in <= imem[PC_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic found;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        IR_in   = 16'h0000;
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        step    = 1'b1;
`endif
        clear_imem();
        imem[0] = 16'h3123;  // ADD  R3 = R1 + R2
        imem[1] = 16'h2A55;  // LOAD R5 <- M[A5]
        imem[2] = 16'h1FF7;  // STORE M[FF] <- R7
        imem[3] = 16'hE000;  // undefined opcode -> NOOP
        imem[4] = 16'h4456;  // SUB  R6 = R4 - R5
        imem[5] = 16'h5000;  // HALT

        // ---- reset state ----
        hold_reset();
        check("rst_state", state_o, INIT);
        check("rst_pc", PC_addr, 0);
        check("rst_dwr", D_wr, 0);
        check("rst_wen", RF_W_en, 0);
        check("rst_alu", Alu_s0, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;
        check("rel_init", state_o, INIT);
        tick();
        check("rel_fetch", state_o, FETCH);

        // ---- ADD ----
        tick();
        check("add_decode", state_o, DECODE);
        check("add_pc_dec", PC_addr, 0);
        tick();
        check("add_state", state_o, ADD);
        check("add_ra", RF_Ra_addr, 1);
        check("add_rb", RF_Rb_addr, 2);
        check("add_wa", RF_W_addr, 3);
        check("add_alu", Alu_s0, 1);
        check("add_wen", RF_W_en, 1);
        check("add_rfs", RF_s, 0);
        check("add_dwr", D_wr, 0);
        check("add_pc", PC_addr, 1);

        // ---- LOAD ----
        tick();
        check("ld_fetch", state_o, FETCH);
        tick();
        tick();
        check("ld_a_state", state_o, LOAD_A);
        check("ld_a_daddr", D_Addr, 8'hA5);
        check("ld_a_wen", RF_W_en, 0);
        check("ld_a_dwr", D_wr, 0);
        check("ld_a_alu", Alu_s0, 0);
        tick();
        check("ld_b_state", state_o, LOAD_B);
        check("ld_b_daddr", D_Addr, 8'hA5);
        check("ld_b_rfs", RF_s, 1);
        check("ld_b_wen", RF_W_en, 1);
        check("ld_b_wa", RF_W_addr, 5);
        check("ld_b_dwr", D_wr, 0);
        tick();
        check("ld_next_fetch", state_o, FETCH);
        check("ld_pc", PC_addr, 2);

        // ---- STORE ----
        tick();
        check("st_dec_dwr", D_wr, 0);
        tick();
        check("st_state", state_o, STORE);
        check("st_daddr", D_Addr, 8'hFF);
        check("st_ra", RF_Ra_addr, 7);
        check("st_dwr", D_wr, 1);
        check("st_wen", RF_W_en, 0);
        tick();
        check("st_dwr_after", D_wr, 0);
        check("st_fetch", state_o, FETCH);

        // ---- opcode E -> NOOP ----
        tick();
        tick();
        check("nop_state", state_o, NOOP);
        check("nop_dwr", D_wr, 0);
        check("nop_wen", RF_W_en, 0);
        check("nop_pc", PC_addr, 4);

        // ---- SUB ----
        tick();
        tick();
        tick();
        check("sub_state", state_o, SUB);
        check("sub_ra", RF_Ra_addr, 4);
        check("sub_rb", RF_Rb_addr, 5);
        check("sub_wa", RF_W_addr, 6);
        check("sub_alu", Alu_s0, 2);
        check("sub_wen", RF_W_en, 1);

        // ---- HALT ----
        tick();
        tick();
        tick();
        check("halt_state", state_o, HALT);
        check("halt_flag", halted, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_pc", PC_addr, 6);
            check("halt_hold", state_o, HALT);
            check("halt_nowr", {30'd0, D_wr, RF_W_en}, 0);
        end

        // ---- async reset mid-STORE ----
        hold_reset();
        clear_imem();
        imem[0] = 16'h1FF7;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("ar_store", state_o, STORE);
        check("ar_dwr_hi", D_wr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_dwr_lo", D_wr, 0);
        check("ar_state", state_o, INIT);
        check("ar_pc", PC_addr, 0);
        check("ar_daddr", D_Addr, 0);
        @(negedge clk);

        // ---- PC wrap on NOOPs ----
        clear_imem();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (PC_addr == 7'd127) found = 1'b1;
        end
        check("wrap_reach", found, 1);
        tick();
        check("wrap_fetch", state_o, FETCH);
        check("wrap_pc127", PC_addr, 127);
        tick();
        tick();
        check("wrap_nop", state_o, NOOP);
        check("wrap_pc0", PC_addr, 0);

`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        // ---- single step ----
        hold_reset();
        step  = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("ss_hold", state_o, FETCH);
            check("ss_pc", PC_addr, 0);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("ss_decode", state_o, DECODE);
        tick();
        check("ss_nop", state_o, NOOP);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("ss_hold2", state_o, FETCH);
            check("ss_pc1", PC_addr, 1);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
